// File: rtl/btn_pkg.sv
// Shared types and default timing constants for the push-button conditioner.
// Optional hold-to-repeat is compiled in when BTN_AUTO_REPEAT_EN is defined.
package btn_pkg;

    typedef enum logic [1:0] {
        RELEASED,
        PRESS_PEND,
        HELD,
        RELEASE_PEND
    } btn_state_t;

    localparam int DEF_DEBOUNCE_CYCLES = 65536;
    localparam int DEF_REPEAT_DELAY    = 25_000_000;
    localparam int DEF_REPEAT_RATE     = 5_000_000;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/btn_channel.sv
// One button: 2-flop sync, debounce FSM, registered level and press/release pulses (DEBOUNCE_CYCLES+2 edges).
// No backpressure; pulses are single-cycle. Repeat pulses built only with BTN_AUTO_REPEAT_EN.
module btn_channel
    import btn_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
    parameter int REPEAT_RATE     = DEF_REPEAT_RATE
) (
    input  logic sysclock,
    input  logic reset,
    input  logic raw,
    output logic clean,
    output logic press,
    output logic release_pulse
);

    localparam int             CW   = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0]  TERM = CW'(DEBOUNCE_CYCLES - 1);

    logic          q1;
    logic          q2;
    logic [CW-1:0] cnt;
    btn_state_t    state;

`ifdef BTN_AUTO_REPEAT_EN
    localparam int RW = $clog2(max_int(REPEAT_DELAY, REPEAT_RATE)) + 1;

    logic [RW-1:0] rcnt;
    logic          rfirst;
    logic          rep_term;

    // The first repeat waits the long delay, later ones the short rate.
    assign rep_term = (rcnt == (rfirst ? RW'(REPEAT_DELAY - 1) : RW'(REPEAT_RATE - 1)));
`else
    logic unused_repeat;
    assign unused_repeat = (REPEAT_DELAY > 0) ^ (REPEAT_RATE > 0);
`endif

    always_ff @(posedge sysclock) begin
        if (reset) begin
            q1            <= 1'b0;
            q2            <= 1'b0;
            cnt           <= '0;
            state         <= RELEASED;
            clean         <= 1'b0;
            press         <= 1'b0;
            release_pulse <= 1'b0;
`ifdef BTN_AUTO_REPEAT_EN
            rcnt          <= '0;
            rfirst        <= 1'b1;
`endif
        end else begin
            q1            <= raw;
            q2            <= q1;
            press         <= 1'b0;
            release_pulse <= 1'b0;

            // The first differing cycle is already counted on the pend entry edge.
            case (state)
                RELEASED: begin
                    cnt <= '0;
                    if (q2) begin
                        state <= PRESS_PEND;
                        cnt   <= CW'(1);
                    end
                end
                PRESS_PEND: begin
                    if (!q2) begin
                        state <= RELEASED;
                        cnt   <= '0;
                    end else if (cnt == TERM) begin
                        state <= HELD;
                        cnt   <= '0;
                        clean <= 1'b1;
                        press <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                HELD: begin
                    cnt <= '0;
                    if (!q2) begin
                        state <= RELEASE_PEND;
                        cnt   <= CW'(1);
                    end
`ifdef BTN_AUTO_REPEAT_EN
                    else if (rep_term) begin
                        press  <= 1'b1;
                        rcnt   <= '0;
                        rfirst <= 1'b0;
                    end else begin
                        rcnt <= rcnt + 1'b1;
                    end
`endif
                end
                RELEASE_PEND: begin
                    if (q2) begin
                        state <= HELD;
                        cnt   <= '0;
                    end else if (cnt == TERM) begin
                        state         <= RELEASED;
                        cnt           <= '0;
                        clean         <= 1'b0;
                        release_pulse <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    state <= RELEASED;
                    cnt   <= '0;
                end
            endcase

`ifdef BTN_AUTO_REPEAT_EN
            if (state == RELEASED) begin
                rcnt   <= '0;
                rfirst <= 1'b1;
            end
`endif
        end
    end

endmodule

// File: rtl/button_conditioner.sv
// Bank of N_BTN independent debounced buttons; clean/press/release_pulse appear DEBOUNCE_CYCLES+2 edges after raw settles.
// No backpressure; hold-to-repeat on press enabled by BTN_AUTO_REPEAT_EN.
module button_conditioner
    import btn_pkg::*;
#(
    parameter int N_BTN           = 4,
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
    parameter int REPEAT_RATE     = DEF_REPEAT_RATE
) (
    input  logic             sysclock,
    input  logic             reset,
    input  logic [N_BTN-1:0] raw,
    output logic [N_BTN-1:0] clean,
    output logic [N_BTN-1:0] press,
    output logic [N_BTN-1:0] release_pulse
);

    for (genvar i = 0; i < N_BTN; i++) begin : g_ch
        btn_channel #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .REPEAT_DELAY   (REPEAT_DELAY),
            .REPEAT_RATE    (REPEAT_RATE)
        ) u_ch (
            .sysclock     (sysclock),
            .reset        (reset),
            .raw          (raw[i]),
            .clean        (clean[i]),
            .press        (press[i]),
            .release_pulse(release_pulse[i])
        );
    end

endmodule

// File: tb/tb_button_conditioner.sv
// Bench for button_conditioner: directed scenarios plus randomized bouncing, checked every cycle against a behavioural model.
module tb_button_conditioner;

    localparam int N  = 4;
    localparam int D  = 8;
    localparam int RD = 20;
    localparam int RR = 5;

    logic         sysclock = 1'b0;
    logic         reset    = 1'b1;
    logic [N-1:0] raw      = '0;
    logic [N-1:0] clean;
    logic [N-1:0] press;
    logic [N-1:0] release_pulse;

    int n_chk  = 0;
    int n_fail = 0;
    bit chk_en = 1'b0;

    button_conditioner #(
        .N_BTN          (N),
        .DEBOUNCE_CYCLES(D),
        .REPEAT_DELAY   (RD),
        .REPEAT_RATE    (RR)
    ) dut (
        .sysclock     (sysclock),
        .reset        (reset),
        .raw          (raw),
        .clean        (clean),
        .press        (press),
        .release_pulse(release_pulse)
    );

    always #5 sysclock = ~sysclock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: sync output is raw two edges late; the level flips after D
    // consecutive edges of disagreement. Repeats fire at RD, RD+RR, ... edges
    // spent steadily held since the press.
    logic [N-1:0] m_q1, m_q2, m_clean, m_press, m_rel;
    int           m_run[N];
    int           m_t[N];

    always @(posedge sysclock) begin
        for (int c = 0; c < N; c++) begin
            if (reset) begin
                m_q1[c] = 1'b0; m_q2[c] = 1'b0; m_clean[c] = 1'b0;
                m_press[c] = 1'b0; m_rel[c] = 1'b0;
                m_run[c] = 0; m_t[c] = 0;
            end else begin
                bit steady_held;
                steady_held = m_clean[c] && (m_run[c] == 0) && m_q2[c];
                m_press[c] = 1'b0;
                m_rel[c]   = 1'b0;
                if (m_q2[c] != m_clean[c]) begin
                    m_run[c]++;
                    if (m_run[c] == D) begin
                        m_clean[c] = ~m_clean[c];
                        m_run[c]   = 0;
                        m_t[c]     = 0;
                        if (m_clean[c]) m_press[c] = 1'b1;
                        else            m_rel[c]   = 1'b1;
                    end
                end else begin
                    m_run[c] = 0;
                end
`ifdef BTN_AUTO_REPEAT_EN
                if (steady_held) begin
                    m_t[c]++;
                    if (m_t[c] >= RD && ((m_t[c] - RD) % RR) == 0) m_press[c] = 1'b1;
                end
`else
                if (steady_held) m_t[c]++;
`endif
                if (!m_clean[c]) m_t[c] = 0;
                m_q2[c] = m_q1[c];
                m_q1[c] = raw[c];
            end
        end
    end

    always @(negedge sysclock) begin
        if (chk_en) begin
            check("model_cmp", {20'd0, clean, press, release_pulse}, {20'd0, m_clean, m_press, m_rel});
            check("press_rel_excl", {28'd0, press & release_pulse}, 32'd0);
        end
    end

    task automatic step(input int n);
        repeat (n) @(negedge sysclock);
    endtask

    int pulses;
    int exp_rep;

    initial begin
        reset = 1'b1;
        raw   = '0;
        step(2);
        chk_en = 1'b1;
        check("reset_outputs", {20'd0, clean, press, release_pulse}, 32'd0);
        reset = 1'b0;

        // Clean press and release on channel 0
        raw = 4'b0001;
        step(9);
        check("press0_early", {28'd0, press}, 32'h0);
        check("clean0_early", {28'd0, clean}, 32'h0);
        step(1);
        check("press0_edge10", {28'd0, press}, 32'h1);
        check("clean0_edge10", {28'd0, clean}, 32'h1);
        step(1);
        check("press0_width", {28'd0, press}, 32'h0);
        raw = 4'b0000;
        step(9);
        check("rel0_early", {28'd0, release_pulse}, 32'h0);
        step(1);
        check("rel0_edge10", {28'd0, release_pulse}, 32'h1);
        check("clean0_off", {28'd0, clean}, 32'h0);
        step(5);

        // Bounce on channel 1
        pulses = 0;
        for (int k = 0; k < 3; k++) begin
            raw[1] = 1'b1;
            for (int j = 0; j < 3 + 2 * k; j++) begin step(1); pulses += press[1]; end
            raw[1] = 1'b0;
            for (int j = 0; j < 2; j++) begin step(1); pulses += press[1]; end
        end
        check("bounce_no_pulse", pulses, 0);
        raw[1] = 1'b1;
        step(9);
        check("bounce_press_early", {28'd0, press}, 32'h0);
        step(1);
        check("bounce_press", {28'd0, press}, 32'h2);
        raw[1] = 1'b0;
        step(14);

        // Release glitch on channel 2
        raw[2] = 1'b1;
        step(12);
        raw[2] = 1'b0;
        step(6);
        raw[2] = 1'b1;
        pulses = 0;
        for (int j = 0; j < 12; j++) begin step(1); pulses += press[2] + release_pulse[2]; end
        check("glitch_no_pulse", pulses, 0);
        check("glitch_clean_held", {28'd0, clean}, 32'h4);
        raw[2] = 1'b0;
        step(9);
        check("rel2_early", {28'd0, release_pulse}, 32'h0);
        step(1);
        check("rel2_edge10", {28'd0, release_pulse}, 32'h4);
        step(5);

        // Reset during PRESS_PEND on channel 3 (count 5 after edge 7)
        raw[3] = 1'b1;
        step(7);
        reset = 1'b1;
        step(1);
        check("midreset_outputs", {20'd0, clean, press, release_pulse}, 32'd0);
        reset = 1'b0;
        step(9);
        check("post_reset_early", {28'd0, press}, 32'h0);
        step(1);
        check("post_reset_press", {28'd0, press}, 32'h8);
        raw = '0;
        step(14);

        // Simultaneous press on every channel
        raw = 4'b1111;
        step(9);
        check("simul_early", {28'd0, press}, 32'h0);
        step(1);
        check("simul_press", {28'd0, press}, 32'hF);
        step(1);
        check("simul_width", {28'd0, press}, 32'h0);
        raw = '0;
        step(14);

        // Hold-to-repeat on channel 0
        raw[0] = 1'b1;
        step(10);
        check("hold_press", {28'd0, press}, 32'h1);
        pulses = 0;
        for (int j = 1; j <= 60; j++) begin
            step(1);
            pulses += press[0];
`ifdef BTN_AUTO_REPEAT_EN
            if (j == 19) check("repeat_before_delay", {31'd0, press[0]}, 32'd0);
            if (j == 20) check("repeat_at_delay", {31'd0, press[0]}, 32'd1);
            if (j == 25) check("repeat_at_rate", {31'd0, press[0]}, 32'd1);
`endif
        end
`ifdef BTN_AUTO_REPEAT_EN
        exp_rep = 9;
`else
        exp_rep = 0;
`endif
        check("repeat_count", pulses, exp_rep);
        raw[0] = 1'b0;
        pulses = 0;
        for (int j = 0; j < 30; j++) begin step(1); pulses += press[0]; end
        check("repeat_stops", pulses, 0);

        // Randomized bouncing with occasional resets
        for (int cyc = 0; cyc < 4000; cyc++) begin
            int toggle_div;
            toggle_div = (cyc % 1000 < 500) ? 12 : 60;
            for (int c = 0; c < N; c++)
                if ($urandom_range(toggle_div - 1) == 0) raw[c] = ~raw[c];
            reset = ($urandom_range(599) == 0);
            step(1);
        end
        reset = 1'b0;
        step(2);

        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end

endmodule
